// File: rtl/queue_dequeue_client_if.sv
// Bundle of the handshake channels around the dequeue client: scheduler
// request input, queue-manager request/response/commit channels, descriptor
// output to the fetch engine, completion input, and status outputs.
// The master modport is the client's view; slave is the surrounding system.
interface queue_dequeue_client_if #(
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int QUEUE_PTR_WIDTH   = 16,
  parameter int ADDR_WIDTH        = 64,
  parameter int REQ_TAG_WIDTH     = 3,
  parameter int OP_TAG_WIDTH      = 8
);

  // scheduler request
  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_req_queue;
  logic                         s_axis_req_valid;
  logic                         s_axis_req_ready;

  // dequeue request to the queue manager
  logic [QUEUE_INDEX_WIDTH-1:0] m_axis_dequeue_req_queue;
  logic [REQ_TAG_WIDTH-1:0]     m_axis_dequeue_req_tag;
  logic                         m_axis_dequeue_req_valid;
  logic                         m_axis_dequeue_req_ready;

  // dequeue response from the queue manager
  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_dequeue_resp_queue;
  logic [QUEUE_PTR_WIDTH-1:0]   s_axis_dequeue_resp_ptr;
  logic [ADDR_WIDTH-1:0]        s_axis_dequeue_resp_addr;
  logic [REQ_TAG_WIDTH-1:0]     s_axis_dequeue_resp_tag;
  logic [OP_TAG_WIDTH-1:0]      s_axis_dequeue_resp_op_tag;
  logic                         s_axis_dequeue_resp_empty;
  logic                         s_axis_dequeue_resp_error;
  logic                         s_axis_dequeue_resp_valid;
  logic                         s_axis_dequeue_resp_ready;

  // descriptor to the fetch engine
  logic [QUEUE_INDEX_WIDTH-1:0] m_axis_desc_queue;
  logic [QUEUE_PTR_WIDTH-1:0]   m_axis_desc_ptr;
  logic [ADDR_WIDTH-1:0]        m_axis_desc_addr;
  logic [REQ_TAG_WIDTH-1:0]     m_axis_desc_tag;
  logic                         m_axis_desc_valid;
  logic                         m_axis_desc_ready;

  // completion from the fetch engine
  logic [REQ_TAG_WIDTH-1:0]     s_axis_done_tag;
  logic                         s_axis_done_valid;
  logic                         s_axis_done_ready;

  // dequeue commit to the queue manager
  logic [OP_TAG_WIDTH-1:0]      m_axis_dequeue_commit_op_tag;
  logic                         m_axis_dequeue_commit_valid;
  logic                         m_axis_dequeue_commit_ready;

  // status
  logic                         status_empty;
  logic                         status_bad_tag;
  logic [REQ_TAG_WIDTH:0]       outstanding;

  modport master (
    input  s_axis_req_queue, s_axis_req_valid,
    output s_axis_req_ready,
    output m_axis_dequeue_req_queue, m_axis_dequeue_req_tag, m_axis_dequeue_req_valid,
    input  m_axis_dequeue_req_ready,
    input  s_axis_dequeue_resp_queue, s_axis_dequeue_resp_ptr, s_axis_dequeue_resp_addr,
    input  s_axis_dequeue_resp_tag, s_axis_dequeue_resp_op_tag,
    input  s_axis_dequeue_resp_empty, s_axis_dequeue_resp_error, s_axis_dequeue_resp_valid,
    output s_axis_dequeue_resp_ready,
    output m_axis_desc_queue, m_axis_desc_ptr, m_axis_desc_addr, m_axis_desc_tag,
    output m_axis_desc_valid,
    input  m_axis_desc_ready,
    input  s_axis_done_tag, s_axis_done_valid,
    output s_axis_done_ready,
    output m_axis_dequeue_commit_op_tag, m_axis_dequeue_commit_valid,
    input  m_axis_dequeue_commit_ready,
    output status_empty, status_bad_tag, outstanding
  );

  modport slave (
    output s_axis_req_queue, s_axis_req_valid,
    input  s_axis_req_ready,
    input  m_axis_dequeue_req_queue, m_axis_dequeue_req_tag, m_axis_dequeue_req_valid,
    output m_axis_dequeue_req_ready,
    output s_axis_dequeue_resp_queue, s_axis_dequeue_resp_ptr, s_axis_dequeue_resp_addr,
    output s_axis_dequeue_resp_tag, s_axis_dequeue_resp_op_tag,
    output s_axis_dequeue_resp_empty, s_axis_dequeue_resp_error, s_axis_dequeue_resp_valid,
    input  s_axis_dequeue_resp_ready,
    input  m_axis_desc_queue, m_axis_desc_ptr, m_axis_desc_addr, m_axis_desc_tag,
    input  m_axis_desc_valid,
    output m_axis_desc_ready,
    output s_axis_done_tag, s_axis_done_valid,
    input  s_axis_done_ready,
    input  m_axis_dequeue_commit_op_tag, m_axis_dequeue_commit_valid,
    output m_axis_dequeue_commit_ready,
    input  status_empty, status_bad_tag, outstanding
  );

endinterface

// File: rtl/queue_dequeue_client.sv
// Dequeue client: turns scheduler requests into tagged queue-manager dequeue
// requests, forwards non-empty responses as descriptors, and issues the
// dequeue commit once the fetch engine reports the tag done.
// Each local tag walks FREE -> REQ -> ACTIVE -> COMMIT -> FREE; an empty or
// error response sends a REQ tag straight back to FREE.
module queue_dequeue_client #(
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int QUEUE_PTR_WIDTH   = 16,
  parameter int ADDR_WIDTH        = 64,
  parameter int REQ_TAG_WIDTH     = 3,
  parameter int OP_TAG_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  queue_dequeue_client_if.master   io_bus
);

  localparam int MAX_OUTSTANDING = 2 ** REQ_TAG_WIDTH;
  localparam int CNT_WIDTH       = REQ_TAG_WIDTH + 1;

  typedef logic [REQ_TAG_WIDTH-1:0] tag_t;
  typedef logic [CNT_WIDTH-1:0]     cnt_t;

  typedef enum logic [1:0] {
    TAG_FREE   = 2'd0,
    TAG_REQ    = 2'd1,
    TAG_ACTIVE = 2'd2,
    TAG_COMMIT = 2'd3
  } tag_state_t;

  // tag table
  tag_state_t              r_tag_state [MAX_OUTSTANDING];
  logic [OP_TAG_WIDTH-1:0] r_tag_op    [MAX_OUTSTANDING];

  // output registers
  logic [QUEUE_INDEX_WIDTH-1:0] r_req_queue;
  tag_t                         r_req_tag;
  logic                         r_req_valid;
  logic [QUEUE_INDEX_WIDTH-1:0] r_desc_queue;
  logic [QUEUE_PTR_WIDTH-1:0]   r_desc_ptr;
  logic [ADDR_WIDTH-1:0]        r_desc_addr;
  tag_t                         r_desc_tag;
  logic                         r_desc_valid;
  logic [OP_TAG_WIDTH-1:0]      r_commit_op;
  tag_t                         r_commit_tag;
  logic                         r_commit_valid;
  logic                         r_status_empty;
  logic                         r_status_bad_tag;
  cnt_t                         r_outstanding;

  // combinational control
  logic w_free_found;
  tag_t w_free_idx;
  logic w_req_ready;
  logic w_req_fire;
  logic w_resp_ready;
  logic w_resp_fire;
  logic w_resp_hit;
  logic w_resp_drop_empty;
  logic w_resp_retire;
  logic w_resp_load;
  logic w_resp_bad;
  logic w_done_ready;
  logic w_done_fire;
  logic w_done_hit;
  logic w_done_load;
  logic w_done_bad;
  logic w_commit_fire;

  // Lowest-index FREE tag; scanned high to low so the lowest match wins.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = {REQ_TAG_WIDTH{1'b0}};
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      w_free_found = w_free_found | (r_tag_state[i] == TAG_FREE);
      w_free_idx   = (r_tag_state[i] == TAG_FREE) ? tag_t'(i) : w_free_idx;
    end
  end

  // Handshake qualification and classification of each incoming event.
  always_comb begin
    w_req_ready       = w_free_found && (!r_req_valid || io_bus.m_axis_dequeue_req_ready);
    w_req_fire        = io_bus.s_axis_req_valid && w_req_ready;

    w_resp_ready      = !r_desc_valid || io_bus.m_axis_desc_ready;
    w_resp_fire       = io_bus.s_axis_dequeue_resp_valid && w_resp_ready;
    w_resp_hit        = (r_tag_state[io_bus.s_axis_dequeue_resp_tag] == TAG_REQ);
    w_resp_drop_empty = io_bus.s_axis_dequeue_resp_empty || io_bus.s_axis_dequeue_resp_error;
    w_resp_retire     = w_resp_fire && w_resp_hit && w_resp_drop_empty;
    w_resp_load       = w_resp_fire && w_resp_hit && !w_resp_drop_empty;
    w_resp_bad        = w_resp_fire && !w_resp_hit;

    w_done_ready      = !r_commit_valid || io_bus.m_axis_dequeue_commit_ready;
    w_done_fire       = io_bus.s_axis_done_valid && w_done_ready;
    w_done_hit        = (r_tag_state[io_bus.s_axis_done_tag] == TAG_ACTIVE);
    w_done_load       = w_done_fire && w_done_hit;
    w_done_bad        = w_done_fire && !w_done_hit;

    w_commit_fire     = r_commit_valid && io_bus.m_axis_dequeue_commit_ready;
  end

  // Tag table state machine; each event targets a tag in a distinct state,
  // so allocation, response retire and commit retire never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tag_state[i] <= TAG_FREE;
        r_tag_op[i]    <= {OP_TAG_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        case (r_tag_state[i])
          TAG_FREE: begin
            if (w_req_fire && (w_free_idx == tag_t'(i))) begin
              r_tag_state[i] <= TAG_REQ;
            end
          end
          TAG_REQ: begin
            if (w_resp_fire && (io_bus.s_axis_dequeue_resp_tag == tag_t'(i))) begin
              if (w_resp_drop_empty) begin
                r_tag_state[i] <= TAG_FREE;
              end else begin
                r_tag_state[i] <= TAG_ACTIVE;
                r_tag_op[i]    <= io_bus.s_axis_dequeue_resp_op_tag;
              end
            end
          end
          TAG_ACTIVE: begin
            if (w_done_fire && (io_bus.s_axis_done_tag == tag_t'(i))) begin
              r_tag_state[i] <= TAG_COMMIT;
            end
          end
          TAG_COMMIT: begin
            if (w_commit_fire && (r_commit_tag == tag_t'(i))) begin
              r_tag_state[i] <= TAG_FREE;
            end
          end
          default: begin
            r_tag_state[i] <= TAG_FREE;
          end
        endcase
      end
    end
  end

  // Dequeue request register: load on accept, drop valid after handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_queue <= {QUEUE_INDEX_WIDTH{1'b0}};
      r_req_tag   <= {REQ_TAG_WIDTH{1'b0}};
      r_req_valid <= 1'b0;
    end else if (w_req_fire) begin
      r_req_queue <= io_bus.s_axis_req_queue;
      r_req_tag   <= w_free_idx;
      r_req_valid <= 1'b1;
    end else if (io_bus.m_axis_dequeue_req_ready) begin
      r_req_valid <= 1'b0;
    end
  end

  // Descriptor register: loaded from a non-empty response for a REQ tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_desc_queue <= {QUEUE_INDEX_WIDTH{1'b0}};
      r_desc_ptr   <= {QUEUE_PTR_WIDTH{1'b0}};
      r_desc_addr  <= {ADDR_WIDTH{1'b0}};
      r_desc_tag   <= {REQ_TAG_WIDTH{1'b0}};
      r_desc_valid <= 1'b0;
    end else if (w_resp_load) begin
      r_desc_queue <= io_bus.s_axis_dequeue_resp_queue;
      r_desc_ptr   <= io_bus.s_axis_dequeue_resp_ptr;
      r_desc_addr  <= io_bus.s_axis_dequeue_resp_addr;
      r_desc_tag   <= io_bus.s_axis_dequeue_resp_tag;
      r_desc_valid <= 1'b1;
    end else if (io_bus.m_axis_desc_ready) begin
      r_desc_valid <= 1'b0;
    end
  end

  // Commit register: carries the op tag stored when the response arrived.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_op    <= {OP_TAG_WIDTH{1'b0}};
      r_commit_tag   <= {REQ_TAG_WIDTH{1'b0}};
      r_commit_valid <= 1'b0;
    end else if (w_done_load) begin
      r_commit_op    <= r_tag_op[io_bus.s_axis_done_tag];
      r_commit_tag   <= io_bus.s_axis_done_tag;
      r_commit_valid <= 1'b1;
    end else if (io_bus.m_axis_dequeue_commit_ready) begin
      r_commit_valid <= 1'b0;
    end
  end

  // Status pulses and the non-FREE count, updated by the net change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status_empty   <= 1'b0;
      r_status_bad_tag <= 1'b0;
      r_outstanding    <= {CNT_WIDTH{1'b0}};
    end else begin
      r_status_empty   <= w_resp_retire;
      r_status_bad_tag <= w_resp_bad || w_done_bad;
      r_outstanding    <= r_outstanding + cnt_t'(w_req_fire)
                          - cnt_t'(w_resp_retire) - cnt_t'(w_commit_fire);
    end
  end

  assign io_bus.s_axis_req_ready             = w_req_ready;
  assign io_bus.m_axis_dequeue_req_queue     = r_req_queue;
  assign io_bus.m_axis_dequeue_req_tag       = r_req_tag;
  assign io_bus.m_axis_dequeue_req_valid     = r_req_valid;
  assign io_bus.s_axis_dequeue_resp_ready    = w_resp_ready;
  assign io_bus.m_axis_desc_queue            = r_desc_queue;
  assign io_bus.m_axis_desc_ptr              = r_desc_ptr;
  assign io_bus.m_axis_desc_addr             = r_desc_addr;
  assign io_bus.m_axis_desc_tag              = r_desc_tag;
  assign io_bus.m_axis_desc_valid            = r_desc_valid;
  assign io_bus.s_axis_done_ready            = w_done_ready;
  assign io_bus.m_axis_dequeue_commit_op_tag = r_commit_op;
  assign io_bus.m_axis_dequeue_commit_valid  = r_commit_valid;
  assign io_bus.status_empty                 = r_status_empty;
  assign io_bus.status_bad_tag               = r_status_bad_tag;
  assign io_bus.outstanding                  = r_outstanding;

endmodule

// File: tb/tb_queue_dequeue_client.sv
// Self-checking bench for queue_dequeue_client. Expected request, descriptor
// and commit beats are pushed to scoreboard queues as stimulus is driven and
// popped when the DUT presents them. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_queue_dequeue_client;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  queue_dequeue_client_if bus_if ();

  queue_dequeue_client dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if.master)
  );

  int total = 0;
  int bad   = 0;

  logic [10:0] sb_req[$];     // {queue, tag}
  logic [90:0] sb_desc[$];    // {queue, ptr, addr, tag}
  logic [7:0]  sb_commit[$];  // op tag

  function automatic logic [127:0] out_snapshot();
    return {9'd0,
            bus_if.m_axis_dequeue_req_valid, bus_if.m_axis_dequeue_req_queue,
            bus_if.m_axis_dequeue_req_tag,
            bus_if.m_axis_desc_valid, bus_if.m_axis_desc_queue, bus_if.m_axis_desc_ptr,
            bus_if.m_axis_desc_addr, bus_if.m_axis_desc_tag,
            bus_if.m_axis_dequeue_commit_valid, bus_if.m_axis_dequeue_commit_op_tag,
            bus_if.status_empty, bus_if.status_bad_tag, bus_if.outstanding};
  endfunction

  task automatic idle_inputs();
    bus_if.s_axis_req_queue            = 8'd0;
    bus_if.s_axis_req_valid            = 1'b0;
    bus_if.m_axis_dequeue_req_ready    = 1'b1;
    bus_if.s_axis_dequeue_resp_queue   = 8'd0;
    bus_if.s_axis_dequeue_resp_ptr     = 16'd0;
    bus_if.s_axis_dequeue_resp_addr    = 64'd0;
    bus_if.s_axis_dequeue_resp_tag     = 3'd0;
    bus_if.s_axis_dequeue_resp_op_tag  = 8'd0;
    bus_if.s_axis_dequeue_resp_empty   = 1'b0;
    bus_if.s_axis_dequeue_resp_error   = 1'b0;
    bus_if.s_axis_dequeue_resp_valid   = 1'b0;
    bus_if.m_axis_desc_ready           = 1'b1;
    bus_if.s_axis_done_tag             = 3'd0;
    bus_if.s_axis_done_valid           = 1'b0;
    bus_if.m_axis_dequeue_commit_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_req.delete();
    sb_desc.delete();
    sb_commit.delete();
  endtask

  // one-cycle request beat; rdy is s_axis_req_ready seen during that cycle
  task automatic req_pulse(input logic [7:0] q, output logic rdy);
    @(posedge clk); #1;
    bus_if.s_axis_req_queue = q;
    bus_if.s_axis_req_valid = 1'b1;
    @(negedge clk);
    rdy = bus_if.s_axis_req_ready;
    @(posedge clk); #1;
    bus_if.s_axis_req_valid = 1'b0;
  endtask

  task automatic resp_pulse(input logic [7:0] q, input logic [15:0] ptr, input logic [63:0] addr,
                            input logic [2:0] tag, input logic [7:0] op, input logic empty,
                            input logic err, output logic rdy);
    @(posedge clk); #1;
    bus_if.s_axis_dequeue_resp_queue  = q;
    bus_if.s_axis_dequeue_resp_ptr    = ptr;
    bus_if.s_axis_dequeue_resp_addr   = addr;
    bus_if.s_axis_dequeue_resp_tag    = tag;
    bus_if.s_axis_dequeue_resp_op_tag = op;
    bus_if.s_axis_dequeue_resp_empty  = empty;
    bus_if.s_axis_dequeue_resp_error  = err;
    bus_if.s_axis_dequeue_resp_valid  = 1'b1;
    @(negedge clk);
    rdy = bus_if.s_axis_dequeue_resp_ready;
    @(posedge clk); #1;
    bus_if.s_axis_dequeue_resp_valid  = 1'b0;
  endtask

  task automatic done_pulse(input logic [2:0] tag, output logic rdy);
    @(posedge clk); #1;
    bus_if.s_axis_done_tag   = tag;
    bus_if.s_axis_done_valid = 1'b1;
    @(negedge clk);
    rdy = bus_if.s_axis_done_ready;
    @(posedge clk); #1;
    bus_if.s_axis_done_valid = 1'b0;
  endtask

  // wait (bounded) for a request handshake; returns at the negedge before it
  task automatic wait_req(output logic found, output logic [10:0] obs, output int waited);
    found = 1'b0; obs = 11'd0; waited = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (bus_if.m_axis_dequeue_req_valid && bus_if.m_axis_dequeue_req_ready) begin
        found = 1'b1;
        obs = {bus_if.m_axis_dequeue_req_queue, bus_if.m_axis_dequeue_req_tag};
      end else begin
        waited++;
      end
    end
  endtask

  task automatic wait_desc(output logic found, output logic [90:0] obs);
    found = 1'b0; obs = 91'd0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (bus_if.m_axis_desc_valid && bus_if.m_axis_desc_ready) begin
        found = 1'b1;
        obs = {bus_if.m_axis_desc_queue, bus_if.m_axis_desc_ptr,
               bus_if.m_axis_desc_addr, bus_if.m_axis_desc_tag};
      end
    end
  endtask

  task automatic wait_commit(output logic found, output logic [7:0] obs);
    found = 1'b0; obs = 8'd0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (bus_if.m_axis_dequeue_commit_valid && bus_if.m_axis_dequeue_commit_ready) begin
        found = 1'b1;
        obs = bus_if.m_axis_dequeue_commit_op_tag;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if (out_snapshot() !== 128'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", out_snapshot());
    end
    total++;
    if (bus_if.s_axis_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready: got %b want 1", bus_if.s_axis_req_ready);
    end
  endtask

  task automatic test_single();
    logic rdy, found; logic [10:0] rq; logic [90:0] dq; logic [7:0] cq; int waited;
    logic [10:0] er; logic [90:0] ed; logic [7:0] ec;
    apply_reset();
    sb_req.push_back({8'd5, 3'd0});
    req_pulse(8'd5, rdy);
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL single_req_ready: got %b want 1", rdy); end
    wait_req(found, rq, waited);
    er = sb_req.pop_front();
    total++;
    if (!found || rq !== er || waited != 0) begin
      bad++; $display("FAIL single_req_out: got %h (found=%0d wait=%0d) want %h wait 0", rq, found, waited, er);
    end
    total++;
    if (bus_if.outstanding !== 4'd1) begin
      bad++; $display("FAIL single_outstanding1: got %0d want 1", bus_if.outstanding);
    end
    sb_desc.push_back({8'd5, 16'h0010, 64'h1000, 3'd0});
    resp_pulse(8'd5, 16'h0010, 64'h1000, 3'd0, 8'h21, 1'b0, 1'b0, rdy);
    wait_desc(found, dq);
    ed = sb_desc.pop_front();
    total++;
    if (!found || dq !== ed || rdy !== 1'b1) begin
      bad++; $display("FAIL single_desc: got %h (found=%0d rdy=%b) want %h", dq, found, rdy, ed);
    end
    sb_commit.push_back(8'h21);
    done_pulse(3'd0, rdy);
    wait_commit(found, cq);
    ec = sb_commit.pop_front();
    total++;
    if (!found || cq !== ec || rdy !== 1'b1) begin
      bad++; $display("FAIL single_commit: got %h (found=%0d rdy=%b) want %h", cq, found, rdy, ec);
    end
    @(negedge clk);
    total++;
    if (bus_if.outstanding !== 4'd0) begin
      bad++; $display("FAIL single_outstanding0: got %0d want 0", bus_if.outstanding);
    end
  endtask

  task automatic test_empty();
    logic rdy, found; logic [10:0] rq, er; int waited;
    apply_reset();
    sb_req.push_back({8'd7, 3'd0});
    req_pulse(8'd7, rdy);
    wait_req(found, rq, waited);
    er = sb_req.pop_front();
    total++;
    if (!found || rq !== er) begin bad++; $display("FAIL empty_req_out: got %h want %h", rq, er); end
    resp_pulse(8'd7, 16'h0001, 64'h2000, 3'd0, 8'h99, 1'b1, 1'b0, rdy);
    @(negedge clk);
    total++;
    if ({bus_if.status_empty, bus_if.m_axis_desc_valid, bus_if.m_axis_dequeue_commit_valid,
         bus_if.outstanding} !== {3'b100, 4'd0}) begin
      bad++; $display("FAIL empty_pulse: got empty=%b desc=%b commit=%b outst=%0d want 1 0 0 0",
                      bus_if.status_empty, bus_if.m_axis_desc_valid,
                      bus_if.m_axis_dequeue_commit_valid, bus_if.outstanding);
    end
    @(negedge clk);
    total++;
    if (bus_if.status_empty !== 1'b0 || bus_if.m_axis_desc_valid !== 1'b0) begin
      bad++; $display("FAIL empty_pulse_end: got empty=%b desc=%b want 0 0",
                      bus_if.status_empty, bus_if.m_axis_desc_valid);
    end
    // error flag behaves like empty; tag 0 must be reused each time
    sb_req.push_back({8'd9, 3'd0});
    req_pulse(8'd9, rdy);
    wait_req(found, rq, waited);
    er = sb_req.pop_front();
    total++;
    if (!found || rq !== er) begin bad++; $display("FAIL empty_reuse: got %h want %h", rq, er); end
    resp_pulse(8'd9, 16'h0002, 64'h2100, 3'd0, 8'h98, 1'b0, 1'b1, rdy);
    @(negedge clk);
    total++;
    if ({bus_if.status_empty, bus_if.m_axis_desc_valid, bus_if.outstanding} !== {2'b10, 4'd0}) begin
      bad++; $display("FAIL error_pulse: got empty=%b desc=%b outst=%0d want 1 0 0",
                      bus_if.status_empty, bus_if.m_axis_desc_valid, bus_if.outstanding);
    end
  endtask

  task automatic test_full();
    logic rdy, found; logic [10:0] rq, er; int waited;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      sb_req.push_back({8'h40 + 8'(i), 3'(i)});
      req_pulse(8'h40 + 8'(i), rdy);
      wait_req(found, rq, waited);
      er = sb_req.pop_front();
      total++;
      if (!found || rq !== er || rdy !== 1'b1) begin
        bad++; $display("FAIL full_alloc%0d: got %h rdy=%b want %h", i, rq, rdy, er);
      end
    end
    @(negedge clk);
    total++;
    if (bus_if.s_axis_req_ready !== 1'b0 || bus_if.outstanding !== 4'd8) begin
      bad++; $display("FAIL full_state: got ready=%b outst=%0d want 0 8",
                      bus_if.s_axis_req_ready, bus_if.outstanding);
    end
    req_pulse(8'hEE, rdy);
    @(negedge clk);
    total++;
    if (rdy !== 1'b0 || bus_if.m_axis_dequeue_req_valid !== 1'b0 || bus_if.outstanding !== 4'd8) begin
      bad++; $display("FAIL full_reject: got rdy=%b reqv=%b outst=%0d want 0 0 8",
                      rdy, bus_if.m_axis_dequeue_req_valid, bus_if.outstanding);
    end
    resp_pulse(8'h45, 16'h0, 64'h0, 3'd5, 8'h0, 1'b1, 1'b0, rdy);
    @(negedge clk);
    total++;
    if (bus_if.s_axis_req_ready !== 1'b1 || bus_if.outstanding !== 4'd7) begin
      bad++; $display("FAIL full_release: got ready=%b outst=%0d want 1 7",
                      bus_if.s_axis_req_ready, bus_if.outstanding);
    end
    sb_req.push_back({8'h99, 3'd5});
    req_pulse(8'h99, rdy);
    wait_req(found, rq, waited);
    er = sb_req.pop_front();
    total++;
    if (!found || rq !== er) begin bad++; $display("FAIL full_realloc: got %h want %h", rq, er); end
  endtask

  task automatic test_backpressure();
    logic rdy, found; logic [10:0] rq, er; logic [90:0] dq, ed; logic [7:0] cq, ec; int waited;
    apply_reset();
    @(posedge clk); #1;
    bus_if.m_axis_desc_ready = 1'b0;
    bus_if.m_axis_dequeue_commit_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb_req.push_back({8'd1 + 8'(i), 3'(i)});
      req_pulse(8'd1 + 8'(i), rdy);
      wait_req(found, rq, waited);
      er = sb_req.pop_front();
      total++;
      if (!found || rq !== er) begin bad++; $display("FAIL bp_req%0d: got %h want %h", i, rq, er); end
    end
    sb_desc.push_back({8'd1, 16'h0100, 64'hA000, 3'd0});
    resp_pulse(8'd1, 16'h0100, 64'hA000, 3'd0, 8'h30, 1'b0, 1'b0, rdy);
    done_pulse(3'd0, rdy);
    sb_commit.push_back(8'h30);
    @(posedge clk); #1;
    bus_if.s_axis_dequeue_resp_queue  = 8'd2;
    bus_if.s_axis_dequeue_resp_ptr    = 16'h0101;
    bus_if.s_axis_dequeue_resp_addr   = 64'hB000;
    bus_if.s_axis_dequeue_resp_tag    = 3'd1;
    bus_if.s_axis_dequeue_resp_op_tag = 8'h31;
    bus_if.s_axis_dequeue_resp_valid  = 1'b1;
    sb_desc.push_back({8'd2, 16'h0101, 64'hB000, 3'd1});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({bus_if.m_axis_desc_valid, bus_if.m_axis_desc_queue, bus_if.m_axis_desc_ptr,
           bus_if.m_axis_desc_addr, bus_if.m_axis_desc_tag} !== {1'b1, sb_desc[0]}) begin
        bad++; $display("FAIL bp_desc_hold%0d: got v=%b %h want %h", c, bus_if.m_axis_desc_valid,
                        {bus_if.m_axis_desc_queue, bus_if.m_axis_desc_ptr,
                         bus_if.m_axis_desc_addr, bus_if.m_axis_desc_tag}, sb_desc[0]);
      end
      total++;
      if ({bus_if.s_axis_dequeue_resp_ready, bus_if.s_axis_done_ready,
           bus_if.m_axis_dequeue_commit_valid, bus_if.m_axis_dequeue_commit_op_tag}
          !== {3'b001, sb_commit[0]}) begin
        bad++; $display("FAIL bp_ready_hold%0d: got rr=%b dr=%b cv=%b op=%h want 0 0 1 %h", c,
                        bus_if.s_axis_dequeue_resp_ready, bus_if.s_axis_done_ready,
                        bus_if.m_axis_dequeue_commit_valid, bus_if.m_axis_dequeue_commit_op_tag,
                        sb_commit[0]);
      end
    end
    @(posedge clk); #1;
    bus_if.m_axis_desc_ready = 1'b1;
    bus_if.m_axis_dequeue_commit_ready = 1'b1;
    wait_desc(found, dq);
    ed = sb_desc.pop_front();
    total++;
    if (!found || dq !== ed) begin bad++; $display("FAIL bp_desc0: got %h want %h", dq, ed); end
    ec = sb_commit.pop_front();
    total++;
    if (bus_if.m_axis_dequeue_commit_valid !== 1'b1 || bus_if.m_axis_dequeue_commit_op_tag !== ec) begin
      bad++; $display("FAIL bp_commit0: got v=%b %h want 1 %h",
                      bus_if.m_axis_dequeue_commit_valid, bus_if.m_axis_dequeue_commit_op_tag, ec);
    end
    @(posedge clk); #1;
    bus_if.s_axis_dequeue_resp_valid = 1'b0;
    wait_desc(found, dq);
    ed = sb_desc.pop_front();
    total++;
    if (!found || dq !== ed) begin bad++; $display("FAIL bp_desc1: got %h want %h", dq, ed); end
    sb_commit.push_back(8'h31);
    done_pulse(3'd1, rdy);
    wait_commit(found, cq);
    ec = sb_commit.pop_front();
    total++;
    if (!found || cq !== ec) begin bad++; $display("FAIL bp_commit1: got %h want %h", cq, ec); end
  endtask

  task automatic test_bad_tag();
    logic rdy, found; logic [10:0] rq, er; logic [90:0] dq, ed; int waited;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      sb_req.push_back({8'h10 + 8'(i), 3'(i)});
      req_pulse(8'h10 + 8'(i), rdy);
      wait_req(found, rq, waited);
      er = sb_req.pop_front();
      total++;
      if (!found || rq !== er) begin bad++; $display("FAIL bad_setup%0d: got %h want %h", i, rq, er); end
    end
    resp_pulse(8'h16, 16'h0006, 64'h6000, 3'd6, 8'h55, 1'b0, 1'b0, rdy);
    @(negedge clk);
    total++;
    if ({bus_if.status_bad_tag, bus_if.m_axis_desc_valid, bus_if.outstanding} !== {2'b10, 4'd3}) begin
      bad++; $display("FAIL bad_resp: got bad=%b desc=%b outst=%0d want 1 0 3",
                      bus_if.status_bad_tag, bus_if.m_axis_desc_valid, bus_if.outstanding);
    end
    @(negedge clk);
    total++;
    if (bus_if.status_bad_tag !== 1'b0) begin
      bad++; $display("FAIL bad_resp_end: got %b want 0", bus_if.status_bad_tag);
    end
    done_pulse(3'd2, rdy);
    @(negedge clk);
    total++;
    if ({bus_if.status_bad_tag, bus_if.m_axis_dequeue_commit_valid, bus_if.outstanding} !== {2'b10, 4'd3}) begin
      bad++; $display("FAIL bad_done: got bad=%b commit=%b outst=%0d want 1 0 3",
                      bus_if.status_bad_tag, bus_if.m_axis_dequeue_commit_valid, bus_if.outstanding);
    end
    sb_req.push_back({8'h13, 3'd3});
    req_pulse(8'h13, rdy);
    wait_req(found, rq, waited);
    er = sb_req.pop_front();
    total++;
    if (!found || rq !== er) begin bad++; $display("FAIL bad_next_alloc: got %h want %h", rq, er); end
    sb_desc.push_back({8'h12, 16'h0002, 64'h2222, 3'd2});
    resp_pulse(8'h12, 16'h0002, 64'h2222, 3'd2, 8'h62, 1'b0, 1'b0, rdy);
    wait_desc(found, dq);
    ed = sb_desc.pop_front();
    total++;
    if (!found || dq !== ed || bus_if.status_bad_tag !== 1'b0) begin
      bad++; $display("FAIL bad_tag2_still_req: got %h bad=%b want %h", dq, bus_if.status_bad_tag, ed);
    end
  endtask

  task automatic test_simultaneous();
    logic rdy, found; logic [10:0] rq, er; logic [90:0] dq, ed; logic [7:0] ec; int waited;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      sb_req.push_back({8'h20 + 8'(i), 3'(i)});
      req_pulse(8'h20 + 8'(i), rdy);
      wait_req(found, rq, waited);
      er = sb_req.pop_front();
      total++;
      if (!found || rq !== er) begin bad++; $display("FAIL sim_setup%0d: got %h want %h", i, rq, er); end
    end
    sb_desc.push_back({8'h23, 16'h0203, 64'h3000, 3'd3});
    resp_pulse(8'h23, 16'h0203, 64'h3000, 3'd3, 8'h77, 1'b0, 1'b0, rdy);
    wait_desc(found, dq);
    ed = sb_desc.pop_front();
    total++;
    if (!found || dq !== ed) begin bad++; $display("FAIL sim_desc3: got %h want %h", dq, ed); end
    @(posedge clk); #1;
    bus_if.m_axis_dequeue_commit_ready = 1'b0;
    done_pulse(3'd3, rdy);
    sb_commit.push_back(8'h77);
    @(posedge clk); #1;
    bus_if.s_axis_req_queue = 8'h55;
    bus_if.s_axis_req_valid = 1'b1;
    bus_if.s_axis_dequeue_resp_tag   = 3'd1;
    bus_if.s_axis_dequeue_resp_empty = 1'b1;
    bus_if.s_axis_dequeue_resp_valid = 1'b1;
    bus_if.m_axis_dequeue_commit_ready = 1'b1;
    sb_req.push_back({8'h55, 3'd4});
    @(negedge clk);
    ec = sb_commit.pop_front();
    total++;
    if ({bus_if.s_axis_req_ready, bus_if.s_axis_dequeue_resp_ready, bus_if.m_axis_dequeue_commit_valid,
         bus_if.m_axis_dequeue_commit_op_tag, bus_if.outstanding} !== {3'b111, ec, 4'd4}) begin
      bad++; $display("FAIL sim_pre: got rq=%b rr=%b cv=%b op=%h outst=%0d want 1 1 1 %h 4",
                      bus_if.s_axis_req_ready, bus_if.s_axis_dequeue_resp_ready,
                      bus_if.m_axis_dequeue_commit_valid, bus_if.m_axis_dequeue_commit_op_tag,
                      bus_if.outstanding, ec);
    end
    @(posedge clk); #1;
    bus_if.s_axis_req_valid = 1'b0;
    bus_if.s_axis_dequeue_resp_valid = 1'b0;
    bus_if.s_axis_dequeue_resp_empty = 1'b0;
    @(negedge clk);
    er = sb_req.pop_front();
    total++;
    if ({bus_if.outstanding, bus_if.status_empty, bus_if.m_axis_dequeue_req_valid,
         bus_if.m_axis_dequeue_req_queue, bus_if.m_axis_dequeue_req_tag} !== {4'd3, 2'b11, er}) begin
      bad++; $display("FAIL sim_post: got outst=%0d empty=%b rv=%b %h want 3 1 1 %h",
                      bus_if.outstanding, bus_if.status_empty, bus_if.m_axis_dequeue_req_valid,
                      {bus_if.m_axis_dequeue_req_queue, bus_if.m_axis_dequeue_req_tag}, er);
    end
    sb_req.push_back({8'h56, 3'd1});
    sb_req.push_back({8'h57, 3'd3});
    for (int i = 0; i < 2; i++) begin
      req_pulse(8'h56 + 8'(i), rdy);
      wait_req(found, rq, waited);
      er = sb_req.pop_front();
      total++;
      if (!found || rq !== er) begin bad++; $display("FAIL sim_realloc%0d: got %h want %h", i, rq, er); end
    end
    total++;
    if (bus_if.outstanding !== 4'd5) begin
      bad++; $display("FAIL sim_outstanding: got %0d want 5", bus_if.outstanding);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, found; logic [10:0] rq, er; int waited;
    @(posedge clk); #1;
    bus_if.s_axis_req_queue = 8'h66;
    bus_if.s_axis_req_valid = 1'b1;
    bus_if.s_axis_dequeue_resp_queue  = 8'h20;
    bus_if.s_axis_dequeue_resp_tag    = 3'd0;
    bus_if.s_axis_dequeue_resp_op_tag = 8'h44;
    bus_if.s_axis_dequeue_resp_valid  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus_if.m_axis_dequeue_req_valid, bus_if.m_axis_desc_valid} !== 2'b11) begin
      bad++; $display("FAIL rstmid_inflight: got rv=%b dv=%b want 1 1",
                      bus_if.m_axis_dequeue_req_valid, bus_if.m_axis_desc_valid);
    end
    @(negedge clk);
    total++;
    if (out_snapshot() !== 128'd0) begin
      bad++; $display("FAIL rstmid_outputs: got %h want 0", out_snapshot());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    sb_req.delete(); sb_desc.delete(); sb_commit.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (out_snapshot() !== 128'd0) begin
        bad++; $display("FAIL rstmid_quiet%0d: got %h want 0", c, out_snapshot());
      end
    end
    sb_req.push_back({8'h70, 3'd0});
    req_pulse(8'h70, rdy);
    wait_req(found, rq, waited);
    er = sb_req.pop_front();
    total++;
    if (!found || rq !== er) begin bad++; $display("FAIL rstmid_alloc: got %h want %h", rq, er); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_empty();
    test_full();
    test_backpressure();
    test_bad_tag();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/queue_dequeue_client.md
Name: queue_dequeue_client

Overview:
- Initiator-side companion to the queue manager.
- Accepts dequeue requests from a scheduler and issues them on the manager's dequeue request channel, tracking each with a local tag.
- Forwards each non-empty response to a downstream engine as a descriptor. When the engine reports completion, issues the matching dequeue commit.
- Sits between the transmit scheduler and the descriptor fetch engine.

Parameters:
QUEUE_INDEX_WIDTH, 8, width of queue index
QUEUE_PTR_WIDTH, 16, width of queue pointer in responses
ADDR_WIDTH, 64, width of descriptor address
REQ_TAG_WIDTH, 3, width of local request tag; MAX_OUTSTANDING = 2**REQ_TAG_WIDTH
OP_TAG_WIDTH, 8, width of queue-manager operation tag

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_req_queue  in  QUEUE_INDEX_WIDTH  queue to dequeue from
s_axis_req_valid  in  1  request valid
s_axis_req_ready  out  1  request accepted
m_axis_dequeue_req_queue  out  QUEUE_INDEX_WIDTH  queue to queue manager
m_axis_dequeue_req_tag  out  REQ_TAG_WIDTH  local tag
m_axis_dequeue_req_valid  out  1  valid
m_axis_dequeue_req_ready  in  1  ready
s_axis_dequeue_resp_queue  in  QUEUE_INDEX_WIDTH  responding queue
s_axis_dequeue_resp_ptr  in  QUEUE_PTR_WIDTH  consumer pointer
s_axis_dequeue_resp_addr  in  ADDR_WIDTH  descriptor address
s_axis_dequeue_resp_tag  in  REQ_TAG_WIDTH  echoed local tag
s_axis_dequeue_resp_op_tag  in  OP_TAG_WIDTH  operation tag for commit
s_axis_dequeue_resp_empty  in  1  queue empty
s_axis_dequeue_resp_error  in  1  queue disabled/invalid
s_axis_dequeue_resp_valid  in  1  valid
s_axis_dequeue_resp_ready  out  1  ready
m_axis_desc_queue  out  QUEUE_INDEX_WIDTH  descriptor queue
m_axis_desc_ptr  out  QUEUE_PTR_WIDTH  descriptor pointer
m_axis_desc_addr  out  ADDR_WIDTH  descriptor address
m_axis_desc_tag  out  REQ_TAG_WIDTH  tag engine returns on done
m_axis_desc_valid  out  1  valid
m_axis_desc_ready  in  1  ready
s_axis_done_tag  in  REQ_TAG_WIDTH  completed tag
s_axis_done_valid  in  1  valid
s_axis_done_ready  out  1  ready
m_axis_dequeue_commit_op_tag  out  OP_TAG_WIDTH  op tag to commit
m_axis_dequeue_commit_valid  out  1  valid
m_axis_dequeue_commit_ready  in  1  ready
status_empty  out  1  one-cycle pulse: empty/error response retired
status_bad_tag  out  1  one-cycle pulse: response/done for non-matching tag
outstanding  out  REQ_TAG_WIDTH+1  tags not FREE

Behaviour:
- Reset:
  - All valids low, status pulses low, outstanding 0.
  - All tag entries FREE; data outputs 0.
  - Reset mid-transaction discards all state; nothing is re-issued.
- Tag table: MAX_OUTSTANDING entries, each with state FREE/REQ/ACTIVE/COMMIT and a stored op_tag.
- Request path:
  - s_axis_req_ready = (a FREE tag exists) && (!m_axis_dequeue_req_valid || m_axis_dequeue_req_ready).
  - On accept: allocate the lowest-index FREE tag and mark it REQ.
  - The output register loads queue and tag; valid rises the next cycle (1-cycle latency).
  - Output is held stable until ready.
- Response path:
  - s_axis_dequeue_resp_ready = !m_axis_desc_valid || m_axis_desc_ready.
  - Tag not in REQ: drop the response, pulse status_bad_tag, leave the table unchanged.
  - empty or error set: entry → FREE, pulse status_empty, no descriptor, no commit.
  - Otherwise: store op_tag, entry → ACTIVE, load the descriptor register (valid next cycle).
- Done path:
  - s_axis_done_ready = !m_axis_dequeue_commit_valid || m_axis_dequeue_commit_ready.
  - Tag not ACTIVE: drop, pulse status_bad_tag.
  - Otherwise: entry → COMMIT and load the commit register with the stored op_tag.
  - On the commit handshake, the entry → FREE.
- Simultaneous events:
  - Allocation, response free, and commit free in the same cycle all apply.
  - A tag freed this cycle is allocatable next cycle, not the same cycle.
  - outstanding updates by net change.
- Full: with all tags non-FREE, s_axis_req_ready = 0. Other paths keep flowing.
- All handshakes are AXI-stream: payload is stable while valid && !ready, and valid never drops without a handshake.

Test Plan:
- Single request queue 5, response tag 0, op_tag 0x21, ptr 0x10, addr 0x1000 → req out 1 cycle later with tag 0. Descriptor (5, 0x10, 0x1000, tag 0). Done tag 0 → commit op_tag 0x21; outstanding 1→0.
- Empty response for tag 0 → status_empty pulse, no descriptor, no commit, tag 0 reusable.
- Issue 8 requests, no responses → s_axis_req_ready low, outstanding 8. One empty response → ready high next cycle, reallocated tag = freed index.
- Hold m_axis_desc_ready and m_axis_dequeue_commit_ready low for 10 cycles → payloads stable, resp_ready and done_ready low. Release → transfers complete in order.
- Response with tag 6 while 6 FREE, and done with tag 2 while 2 REQ → status_bad_tag pulses twice, table unchanged.
- Same cycle: new request accepted, empty response frees tag 1, commit frees tag 3 → outstanding changes by −1; both tags FREE next cycle. Assert rst mid-burst → all outputs 0 next cycle.
